// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control unit: sequences fetch, decode, execute,
// branch, memory and writeback for one instruction at a time.
module multicycle_ctrl #(
  parameter int unsigned               DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     PC_ADDR    = 32'h8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] ir_o,
  output logic                  alu_a_sel_o,
  output logic                  alu_b_sel_o,
  output logic [3:0]            alu_op_o,
  output logic                  rf_we_o,
  output logic [1:0]            wb_sel_o,
  output logic                  illegal_o,
  output logic                  retire_o
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_BR, S_MEM, S_WB} state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_SLT  = 4'd8, ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_PC4 = 2'd3;

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_target;
  logic                  r_mem_req;
  logic [1:0]            r_wb_sel;
  logic                  r_retire;
  logic                  r_illegal;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic                  w_funct7_b5;
  logic [4:0]            w_rd;
  logic                  w_legal;
  logic                  w_taken;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic                  w_a_sel;
  logic                  w_b_sel;
  alu_op_e               w_alu_op;

  assign w_opcode    = r_ir[6:0];
  assign w_funct3    = r_ir[14:12];
  assign w_funct7_b5 = r_ir[30];
  assign w_rd        = r_ir[11:7];

  // Dedicated incrementer so the ALU stays free; wraps naturally at 2^32.
  assign w_pc_plus4  = r_pc + DATA_WIDTH'(4);

  assign w_legal = (w_opcode == OPC_OP)    || (w_opcode == OPC_OPIMM) ||
                   (w_opcode == OPC_LUI)   || (w_opcode == OPC_AUIPC) ||
                   (w_opcode == OPC_JAL)   || (w_opcode == OPC_LOAD)  ||
                   (w_opcode == OPC_STORE) ||
                   ((w_opcode == OPC_BRANCH) && (w_funct3[2:1] == 2'b00));

  // funct3[0] distinguishes BNE from BEQ.
  assign w_taken = w_funct3[0] ? !alu_zero_i : alu_zero_i;

  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    w_a_sel  = 1'b0;
    w_b_sel  = 1'b0;
    w_alu_op = ALU_ADD;
    case (r_state)
      S_EX: begin
        case (w_opcode)
          OPC_OP:     w_alu_op = f3_to_op(w_funct3, w_funct7_b5);
          OPC_OPIMM: begin
            w_b_sel  = 1'b1;
            w_alu_op = f3_to_op(w_funct3, w_funct7_b5 && (w_funct3 == 3'b101));
          end
          OPC_AUIPC, OPC_JAL: begin
            w_a_sel = 1'b1;
            w_b_sel = 1'b1;
          end
          OPC_BRANCH: w_alu_op = ALU_SUB;
          OPC_LOAD, OPC_STORE: w_b_sel = 1'b1;
          default: ;
        endcase
      end
      S_BR: begin
        w_a_sel = 1'b1;
        w_b_sel = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IF;
      r_pc      <= PC_ADDR;
      r_ir      <= '0;
      r_addr    <= '0;
      r_target  <= '0;
      r_mem_req <= 1'b0;
      r_wb_sel  <= WB_ALU;
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in a branch override the pulse defaults.
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IF: begin
          // An ack only counts once our request is actually on the bus.
          if (r_mem_req && mem_ack_i) begin
            r_ir      <= mem_rdata_i;
            r_mem_req <= 1'b0;
            r_state   <= S_ID;
          end else begin
            r_mem_req <= 1'b1;
          end
        end
        S_ID: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_retire  <= 1'b1;
            r_pc      <= w_pc_plus4;
            r_mem_req <= 1'b1;
            r_state   <= S_IF;
          end else begin
            case (w_opcode)
              OPC_LOAD: r_wb_sel <= WB_MEM;
              OPC_LUI:  r_wb_sel <= WB_IMM;
              OPC_JAL:  r_wb_sel <= WB_PC4;
              default:  r_wb_sel <= WB_ALU;
            endcase
            r_state <= S_EX;
          end
        end
        S_EX: begin
          case (w_opcode)
            OPC_BRANCH: begin
              if (w_taken) begin
                r_state <= S_BR;
              end else begin
                r_pc      <= w_pc_plus4;
                r_retire  <= 1'b1;
                r_mem_req <= 1'b1;
                r_state   <= S_IF;
              end
            end
            OPC_LOAD, OPC_STORE: begin
              r_addr    <= alu_result_i;
              r_mem_req <= 1'b1;
              r_state   <= S_MEM;
            end
            OPC_JAL: begin
              r_target <= alu_result_i;
              r_state  <= S_WB;
            end
            default: r_state <= S_WB;
          endcase
        end
        S_BR: begin
          r_pc      <= alu_result_i;
          r_retire  <= 1'b1;
          r_mem_req <= 1'b1;
          r_state   <= S_IF;
        end
        S_MEM: begin
          if (mem_ack_i) begin
            if (w_opcode == OPC_STORE) begin
              r_pc      <= w_pc_plus4;
              r_retire  <= 1'b1;
              r_mem_req <= 1'b1;
              r_state   <= S_IF;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= S_WB;
            end
          end
        end
        S_WB: begin
          r_pc      <= (w_opcode == OPC_JAL) ? r_target : w_pc_plus4;
          r_retire  <= 1'b1;
          r_mem_req <= 1'b1;
          r_state   <= S_IF;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IF;
        end
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = (r_state == S_MEM) && (w_opcode == OPC_STORE);
  assign mem_addr_o  = (r_state == S_MEM) ? r_addr : r_pc;
  assign pc_o        = r_pc;
  assign ir_o        = r_ir;
  assign alu_a_sel_o = w_a_sel;
  assign alu_b_sel_o = w_b_sel;
  assign alu_op_o    = w_alu_op;
  assign rf_we_o     = (r_state == S_WB) && (w_rd != 5'd0);
  assign wb_sel_o    = r_wb_sel;
  assign illegal_o   = r_illegal;
  assign retire_o    = r_retire;

endmodule
